// File: rtl/add_accum.sv
// add_accum: batch accumulator behind an adder stage.
// Sums len samples exactly and reports the low bits plus signed overflow.
module add_accum #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  // Wide enough that 2^CNT_W-1 full-scale samples
  // of either signedness never wrap.
  localparam int ACC_W = WIDTH + CNT_W + 1;
  localparam int EXT_W = ACC_W - WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [WIDTH-1:0]        res_q, res_d;
  logic                    ovf_q, ovf_d;

  logic                    st_idle;
  logic                    st_acc;
  logic                    st_done;
  logic                    take;
  logic                    last;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic [EXT_W:0]          hi;
  logic                    sum_ovf;

  assign st_idle = (state_q == S_IDLE);
  assign st_acc  = (state_q == S_ACC);
  assign st_done = (state_q == S_DONE);

  assign in_ready  = st_acc;
  assign out_valid = st_done;
  assign busy      = st_acc | st_done;
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;

  assign take = in_valid & st_acc;

  // Extend the sample, add it, and judge signed range of the result.
  always_comb begin
    ext = $signed({{EXT_W{in_signed & in_data[WIDTH-1]}},
                   in_data});
    sum = acc_q + ext;
    cnt_inc = cnt_q + CNT_ONE;
    last = (cnt_inc == len_q);
    hi = sum[ACC_W-1:WIDTH-1];
    sum_ovf = !((&hi) || (~|hi));
  end

  // Batch sequencing: arm on start, sum samples, hold result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      st_idle: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          len_d = len;
          if (len == '0) begin
            state_d = S_DONE;
            res_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      st_acc: begin
        if (take) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (last) begin
            state_d = S_DONE;
            res_d   = sum[WIDTH-1:0];
            ovf_d   = sum_ovf;
          end
        end
      end
      st_done: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops any batch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: scoreboard bench for add_accum.
// Expected batch results are queued at drive time, popped on handoff.
module tb_add_accum;

  localparam int W  = 64;
  localparam int CW = 8;
  localparam int AW = W + CW + 1;

  localparam logic signed [AW-1:0] MAXV = {10'b0, {63{1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{10{1'b1}}, 63'b0};

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  exp_t          sb[$];
  exp_t          e;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [W-1:0]  smp[256];
  logic          sg[256];

  logic          prev_v = 1'b0;
  logic          prev_hs = 1'b0;
  logic [W-1:0]  prev_d = '0;
  logic          prev_o = 1'b0;

  add_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .busy(busy),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    logic signed [AW-1:0] s;
    exp_t r;
    s = '0;
    for (int i = 0; i < n; i++) begin
      if (sg[i]) s = s + {{(AW-W){smp[i][W-1]}}, smp[i]};
      else       s = s + {{(AW-W){1'b0}}, smp[i]};
    end
    r.d = s[W-1:0];
    r.o = (s > MAXV) || (s < MINV);
    return r;
  endfunction

  // Result monitor: pop on handoff, check hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        chk("busy_done", 64'(busy), 64'd1);
        if (prev_v && !prev_hs) begin
          chk("hold_data", out_data, prev_d);
          chk("hold_ovf", 64'(out_ovf), 64'(prev_o));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sum", out_data, e.d);
            chk("ovf", 64'(out_ovf), 64'(e.o));
          end
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid && out_ready;
      prev_d  = out_data;
      prev_o  = out_ovf;
    end
  end

  task automatic run_batch(input int n, input bit gaps,
                           input bit poke, input int hold,
                           input bit hs_start);
    int i;
    int budget;
    sb.push_back(model(n));
    @(posedge clk); #1;
    start = 1'b1;
    len = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    budget = 0;
    while (i < n && budget < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = smp[i];
      in_signed = sg[i];
      if (poke) begin
        start = 1'b1;
        len = CW'(7);
      end
      @(negedge clk);
      budget++;
      chk("rdy_acc", 64'(in_ready), 64'd1);
      if (in_valid) i++;
      @(posedge clk); #1;
    end
    if (i < n) chk("timeout", 64'(i), 64'(n));
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("lat", 64'(out_valid), 64'd1);
    repeat (hold) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("stall_v", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = hs_start;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_v", 64'(out_valid), 64'd0);
    chk("idle_b", 64'(busy), 64'd0);
    @(negedge clk);
    chk("idle_b2", 64'(busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, 64'(out_valid), 64'd0);
    chk({tag, "_r"}, 64'(in_ready), 64'd0);
    chk({tag, "_b"}, 64'(busy), 64'd0);
    chk({tag, "_d"}, out_data, 64'd0);
    chk({tag, "_o"}, 64'(out_ovf), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_zero("post_rst");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      smp[i] = 64'(i + 1);
      sg[i] = 1'b0;
    end
    run_batch(4, 1'b0, 1'b0, 0, 1'b0);

    smp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    smp[1] = 64'd4;
    sg[0] = 1'b1;
    sg[1] = 1'b1;
    run_batch(2, 1'b0, 1'b0, 0, 1'b0);
    sg[0] = 1'b0;
    sg[1] = 1'b0;
    run_batch(2, 1'b0, 1'b0, 1, 1'b0);

    smp[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    smp[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    sg[0] = 1'b1;
    sg[1] = 1'b1;
    run_batch(2, 1'b0, 1'b0, 0, 1'b0);

    run_batch(0, 1'b0, 1'b0, 5, 1'b0);

    for (int i = 0; i < 3; i++) begin
      smp[i] = 64'(i + 5);
      sg[i] = 1'b0;
    end
    run_batch(3, 1'b1, 1'b1, 2, 1'b0);

    smp[0] = 64'h8000_0000_0000_0000;
    sg[0] = 1'b1;
    run_batch(1, 1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      smp[i] = {$urandom(), $urandom()};
      sg[i] = 1'($urandom_range(0, 1));
    end
    run_batch(10, 1'b1, 1'b0, 3, 1'b0);

    for (int i = 0; i < 255; i++) begin
      smp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      sg[i] = 1'b0;
    end
    run_batch(255, 1'b0, 1'b0, 0, 1'b0);

    @(posedge clk); #1;
    start = 1'b1;
    len = CW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 64'd100;
    in_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_zero("after_rst");
    end
    smp[0] = 64'd7;
    sg[0] = 1'b0;
    run_batch(1, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_accum.md
ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter CNT_W, default 8, width of the batch-length field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a batch; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of samples in the batch; latched on accepted start.
REQ-007 busy  output  1  high in ACC and DONE.
REQ-008 in_valid  input  1  upstream sum available.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 in_data  input  WIDTH  sample from the upstream adder stage.
REQ-011 in_signed  input  1  1: in_data is two's-complement; 0: in_data is unsigned; sampled per accepted sample.
REQ-012 out_valid  output  1  batch result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  WIDTH  low WIDTH bits of the exact batch sum.
REQ-015 out_ovf  output  1  exact sum not representable as signed WIDTH-bit value.

Function
REQ-016 The FSM SHALL have states IDLE, ACC, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 SHALL clear the accumulator and sample counter, latch len, and go to ACC next cycle, or to DONE with sum 0 when len=0.
REQ-018 ACC: in_ready SHALL be 1; a sample is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-019 Each accepted sample SHALL be extended to the internal width: sign-extended if in_signed=1, zero-extended if in_signed=0.
REQ-020 Internal accumulator SHALL be signed, WIDTH+CNT_W+1 bits, so no intermediate wrap occurs for any len.
REQ-021 On the accepted sample that makes the count equal the latched len, the FSM SHALL go to DONE; the sum including that sample SHALL be visible on out_data in the first DONE cycle.
REQ-022 DONE: out_valid=1; out_data and out_ovf SHALL hold stable until out_valid and out_ready are both 1, then the FSM SHALL return to IDLE next cycle.
REQ-023 out_ovf SHALL be 1 iff the accumulator value is below -2^(WIDTH-1) or above 2^(WIDTH-1)-1.
REQ-024 start SHALL be ignored in ACC and DONE; len changes after latching SHALL have no effect.
REQ-025 in_valid in IDLE and DONE SHALL be ignored; no sample is consumed.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 start in the same cycle as result handoff in DONE SHALL be ignored; a new batch starts from IDLE only.
REQ-028 Latency: result available one cycle after the last accepted sample; back-to-back samples accepted every cycle in ACC.
REQ-029 len = 2^CNT_W-1 SHALL be supported without counter wrap.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, accumulator=0, counter=0, in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
REQ-031 Reset asserted mid-batch or during DONE SHALL discard the batch; after release no partial result is ever presented.
REQ-032 Outputs SHALL stay at reset values until the first accepted start after release.

Verification
REQ-033 len=4, samples (unsigned) 1,2,3,4 back-to-back -> out_data=10, out_ovf=0, out_valid one cycle after 4th accept.
REQ-034 len=2, signed -2 (0xFFFF_FFFF_FFFF_FFFE) then signed 4 -> out_data=2, out_ovf=0; same words with in_signed=0 -> out_data=2, out_ovf=1.
REQ-035 len=2, signed 0x7FFF_FFFF_FFFF_FFFF twice -> out_data=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1.
REQ-036 len=0 start -> DONE with out_data=0, out_ovf=0; out_ready held low 5 cycles -> out_valid and out_data stable throughout.
REQ-037 len=3, in_valid toggling with gaps, start pulsed in ACC -> only 3 samples summed, second start ignored.
REQ-038 rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; new batch len=1 sample 7 -> out_data=7.
